// File: rtl/pos_move_scheduler.sv
// pos_move_scheduler: arbitrates button steps and host commands onto the cursor
// position registers, with saturation, sticky edge-hit flags and atomic snapshot.
module pos_move_scheduler #(
    parameter int         STEP_DIV = 4,
    parameter logic [7:0] X_MAX    = 8'd255,
    parameter logic [7:0] Y_MAX    = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dir_udlr,
    input  logic       host_req,
    input  logic [1:0] host_cmd,
    input  logic [7:0] host_x,
    input  logic [7:0] host_y,
    output logic       host_ack,
    input  logic       snap_req,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] snap_x,
    output logic [7:0] snap_y,
    output logic [7:0] snap_status,
    output logic [7:0] status
);
    localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [0:0] IDLE = 1'b0, APPLY = 1'b1;

    // Returns {hit_min, hit_max, value} for one saturating unit step.
    function automatic logic [9:0] sat_step(input logic [7:0] v, input logic inc,
                                            input logic dec, input logic [7:0] mx);
        sat_step = (inc && !dec) ? ((v >= mx) ? {2'b01, v} : {2'b00, v + 8'd1})
                 : (dec && !inc) ? ((v == 8'd0) ? {2'b10, v} : {2'b00, v - 8'd1})
                 : {2'b00, v};
    endfunction

    logic [0:0]    state_q, state_d;
    logic          grant_host_q, grant_host_d;
    logic          last_grant_q, last_grant_d;
    logic          btn_pend_q, btn_pend_d;
    logic [3:0]    btn_dir_q, btn_dir_d;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    x_q, x_d, y_q, y_d;
    logic [3:0]    hit_q, hit_d;
    logic [7:0]    snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_st_q, snap_st_d;
    logic          tick, arm, idle, apply, hreq, do_move, do_set, do_home;
    logic [3:0]    mv;
    logic [9:0]    xs, ys;

    always_comb begin
        idle         = state_q == IDLE;
        apply        = state_q == APPLY;
        tick         = div_q == DIV_LAST;
        arm          = tick && ((dir_udlr[3] ^ dir_udlr[2]) || (dir_udlr[1] ^ dir_udlr[0]));
        hreq         = host_req && idle;
        mv           = grant_host_q ? host_x[3:0] : btn_dir_q;
        xs           = sat_step(x_q, mv[0], mv[1], X_MAX);
        ys           = sat_step(y_q, mv[3], mv[2], Y_MAX);
        do_move      = apply && (!grant_host_q || host_cmd == 2'b00);
        do_set       = apply && grant_host_q && host_cmd == 2'b01;
        do_home      = apply && grant_host_q && host_cmd == 2'b10;
        x_d          = do_move ? xs[7:0] : do_set ? ((host_x > X_MAX) ? X_MAX : host_x)
                     : do_home ? 8'd0 : x_q;
        y_d          = do_move ? ys[7:0] : do_set ? ((host_y > Y_MAX) ? Y_MAX : host_y)
                     : do_home ? 8'd0 : y_q;
        hit_d        = (snap_req ? 4'd0 : hit_q) | (do_move ? {xs[9:8], ys[9:8]} : 4'd0);
        btn_pend_d   = arm ? 1'b1 : (apply && !grant_host_q) ? 1'b0 : btn_pend_q;
        btn_dir_d    = arm ? dir_udlr : btn_dir_q;
        div_d        = tick ? '0 : div_q + DW'(1);
        // On contention the requester that did not win last time gets the slot.
        grant_host_d = idle ? hreq && (!btn_pend_q || !last_grant_q) : grant_host_q;
        state_d      = (idle && (hreq || btn_pend_q)) ? APPLY : IDLE;
        last_grant_d = apply ? grant_host_q : last_grant_q;
        snap_x_d     = snap_req ? x_q : snap_x_q;
        snap_y_d     = snap_req ? y_q : snap_y_q;
        snap_st_d    = snap_req ? status : snap_st_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_host_q <= 1'b0;
            last_grant_q <= 1'b1;
            btn_pend_q   <= 1'b0;
            btn_dir_q    <= 4'd0;
            div_q        <= '0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            hit_q        <= 4'd0;
            snap_x_q     <= 8'd0;
            snap_y_q     <= 8'd0;
            snap_st_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_host_q <= grant_host_d;
            last_grant_q <= last_grant_d;
            btn_pend_q   <= btn_pend_d;
            btn_dir_q    <= btn_dir_d;
            div_q        <= div_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hit_q        <= hit_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_st_q    <= snap_st_d;
        end
    end

    assign host_ack    = apply && grant_host_q && !rst;
    assign status      = {apply, btn_pend_q, last_grant_q, 1'b0, hit_q};
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign snap_x      = snap_x_q;
    assign snap_y      = snap_y_q;
    assign snap_status = snap_st_q;
endmodule

// File: tb/tb_pos_move_scheduler.sv
// tb_pos_move_scheduler: directed and randomized checks of pos_move_scheduler
// against a transaction-level model of cursor moves, arbitration and snapshots.
module tb_pos_move_scheduler;
    localparam int SD = 4;
    localparam int XM = 100;
    localparam int YM = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dir_udlr = 4'd0;
    logic       host_req = 1'b0;
    logic [1:0] host_cmd = 2'd0;
    logic [7:0] host_x = 8'd0, host_y = 8'd0;
    logic       host_ack;
    logic       snap_req = 1'b0;
    logic [7:0] x_pos, y_pos, snap_x, snap_y, snap_status, status;

    always #5 clk = ~clk;

    pos_move_scheduler #(.STEP_DIV(SD), .X_MAX(8'(XM)), .Y_MAX(8'(YM))) dut (
        .clk(clk), .rst(rst), .dir_udlr(dir_udlr), .host_req(host_req),
        .host_cmd(host_cmd), .host_x(host_x), .host_y(host_y), .host_ack(host_ack),
        .snap_req(snap_req), .x_pos(x_pos), .y_pos(y_pos), .snap_x(snap_x),
        .snap_y(snap_y), .snap_status(snap_status), .status(status)
    );

    int checks = 0, passed = 0, acks = 0;
    bit prev_ack = 1'b0;

    // Model: m_op is the transaction granted last cycle (0 none, 1 button, 2 host).
    int m_x = 0, m_y = 0, m_div = 0, m_op = 0;
    bit m_pend = 1'b0, m_lg = 1'b1;
    logic [3:0] m_dir = 4'd0, m_hit = 4'd0;
    logic [7:0] m_sx = 8'd0, m_sy = 8'd0, m_ss = 8'd0;

    function automatic logic [7:0] m_status();
        return {(m_op != 0), m_pend, m_lg, 1'b0, m_hit};
    endfunction

    task automatic cmp(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    endtask

    task automatic check();
        cmp("x_pos", x_pos, 8'(m_x));
        cmp("y_pos", y_pos, 8'(m_y));
        cmp("status", status, m_status());
        cmp("snap_x", snap_x, m_sx);
        cmp("snap_y", snap_y, m_sy);
        cmp("snap_status", snap_status, m_ss);
        cmp("host_ack", 8'(host_ack), 8'(m_op == 2 && !rst));
        if (host_ack === 1'b1) acks++;
        prev_ack = host_ack === 1'b1;
    endtask

    task automatic model_step();
        int op_old, nx, ny;
        bit pend_old, lg_old, tick;
        logic [3:0] d;
        logic [7:0] st_old;
        if (rst) begin
            m_x = 0; m_y = 0; m_div = 0; m_op = 0; m_pend = 0; m_lg = 1;
            m_dir = 0; m_hit = 0; m_sx = 0; m_sy = 0; m_ss = 0;
            return;
        end
        st_old = m_status(); op_old = m_op; pend_old = m_pend; lg_old = m_lg;
        tick = m_div == SD - 1;
        m_div = (m_div + 1) % SD;
        if (snap_req) begin
            m_sx = 8'(m_x); m_sy = 8'(m_y); m_ss = st_old; m_hit = 0;
        end
        if (op_old == 1 || (op_old == 2 && host_cmd == 2'b00)) begin
            d  = (op_old == 1) ? m_dir : host_x[3:0];
            nx = m_x + int'(d[0]) - int'(d[1]);
            ny = m_y + int'(d[3]) - int'(d[2]);
            if (nx < 0) begin nx = 0; m_hit[3] = 1; end
            if (nx > XM) begin nx = XM; m_hit[2] = 1; end
            if (ny < 0) begin ny = 0; m_hit[1] = 1; end
            if (ny > YM) begin ny = YM; m_hit[0] = 1; end
            m_x = nx; m_y = ny;
        end else if (op_old == 2 && host_cmd == 2'b01) begin
            m_x = (int'(host_x) > XM) ? XM : int'(host_x);
            m_y = (int'(host_y) > YM) ? YM : int'(host_y);
        end else if (op_old == 2 && host_cmd == 2'b10) begin
            m_x = 0; m_y = 0;
        end
        if (op_old == 1) begin m_pend = 0; m_lg = 0; end
        if (op_old == 2) m_lg = 1;
        if (tick && (dir_udlr[3] != dir_udlr[2] || dir_udlr[1] != dir_udlr[0])) begin
            m_pend = 1; m_dir = dir_udlr;
        end
        if (op_old != 0) m_op = 0;
        else if (pend_old && host_req) m_op = lg_old ? 1 : 2;
        else if (pend_old) m_op = 1;
        else if (host_req) m_op = 2;
    endtask

    task automatic step_clk();
        #1 check();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; host_req = 0; dir_udlr = 0; snap_req = 0;
        step_clk();
        rst = 0; acks = 0;
    endtask

    task automatic host(input logic [1:0] c, input logic [7:0] hx, input logic [7:0] hy);
        host_req = 1; host_cmd = c; host_x = hx; host_y = hy;
    endtask

    initial begin
        @(negedge clk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 0;
        cmp("rst_status", status, 8'h20);
        cmp("rst_x", x_pos, 8'h00);

        dir_udlr = 4'b0001;
        repeat (18) step_clk();
        dir_udlr = 0;
        cmp("right_x", x_pos, 8'd4);
        cmp("right_y", y_pos, 8'd0);
        cmp("right_acks", 8'(acks), 8'd0);

        do_reset();
        dir_udlr = 4'b0010;
        repeat (6) step_clk();
        dir_udlr = 0;
        cmp("left_x", x_pos, 8'd0);
        cmp("hit_xmin", 8'(status[3]), 8'd1);
        snap_req = 1;
        step_clk();
        snap_req = 0;
        cmp("snap_hit_xmin", 8'(snap_status[3]), 8'd1);
        cmp("hit_xmin_clr", 8'(status[3]), 8'd0);

        do_reset();
        dir_udlr = 4'b0001;
        repeat (4) step_clk();
        dir_udlr = 0;
        host(2'b01, 8'h20, 8'h30);
        repeat (2) step_clk();
        cmp("arb_btn_first", x_pos, 8'h01);
        repeat (2) step_clk();
        host_req = 0;
        cmp("arb_set_x", x_pos, 8'h20);
        cmp("arb_set_y", y_pos, 8'h30);
        cmp("arb_acks", 8'(acks), 8'd1);
        dir_udlr = 4'b0001;
        repeat (4) step_clk();
        host(2'b01, 8'h40, 8'h50);
        repeat (2) step_clk();
        cmp("arb_btn_again_x", x_pos, 8'h21);
        cmp("arb_btn_again_y", y_pos, 8'h30);
        repeat (2) step_clk();
        host_req = 0; dir_udlr = 0;
        step_clk();

        do_reset();
        host(2'b01, 8'd200, 8'd5);
        repeat (2) step_clk();
        host_req = 0;
        cmp("clamp_x", x_pos, 8'd100);
        cmp("clamp_y", y_pos, 8'd5);
        cmp("clamp_hits", 8'(status[3:0]), 8'd0);
        step_clk();
        acks = 0;
        host(2'b10, 8'd0, 8'd0);
        repeat (2) step_clk();
        host_req = 0;
        step_clk();
        cmp("home_x", x_pos, 8'd0);
        cmp("home_y", y_pos, 8'd0);
        cmp("home_acks", 8'(acks), 8'd1);

        do_reset();
        host(2'b01, 8'h10, 8'h10);
        repeat (2) step_clk();
        host_req = 0;
        dir_udlr = 4'b1100;
        repeat (8) step_clk();
        cmp("ud_pend", 8'(status[6]), 8'd0);
        dir_udlr = 4'b0011;
        repeat (8) step_clk();
        dir_udlr = 0;
        cmp("lr_pend", 8'(status[6]), 8'd0);
        cmp("null_x", x_pos, 8'h10);
        acks = 0;
        host(2'b11, 8'h55, 8'h66);
        repeat (2) step_clk();
        host_req = 0;
        step_clk();
        cmp("rsv_acks", 8'(acks), 8'd1);
        cmp("rsv_y", y_pos, 8'h10);

        do_reset();
        host(2'b01, 8'h11, 8'h22);
        step_clk();
        rst = 1;
        step_clk();
        rst = 0;
        cmp("abort_x", x_pos, 8'd0);
        cmp("abort_acks", 8'(acks), 8'd0);
        repeat (2) step_clk();
        host_req = 0;
        step_clk();
        cmp("retry_x", x_pos, 8'h11);
        cmp("retry_y", y_pos, 8'h22);
        cmp("retry_acks", 8'(acks), 8'd1);

        repeat (3000) begin
            rst = $urandom_range(0, 199) == 0;
            if (host_req && prev_ack) host_req = 0;
            else if (!host_req && $urandom_range(0, 3) == 0)
                host(2'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) dir_udlr = 4'($urandom);
            snap_req = $urandom_range(0, 5) == 0;
            step_clk();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
